imem_fetch_unit: RTL and testbench

Parametrised, clocked instruction memory with a request/valid fetch handshake, configurable wait states and a program-load write port. Sits between the MIPS core's PC/fetch stage and a word-organised instruction store. Misaligned and out-of-range byte addresses return a zero word with explicit error flags instead of silently reading zero. Program contents are written through the load port, not hard-wired constants.

---
 rtl/imem_fetch_unit_if.sv | 16 +
 rtl/imem_fetch_unit.sv | 102 ++++++++++
 tb/tb_imem_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_unit_if.sv
// Fetch handshake between the PC/fetch stage (master) and the instruction memory (slave).
interface imem_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req;
  logic [ADDR_W-1:0] sel;
  logic              ready;
  logic              valid;
  logic [DATA_W-1:0] out;
  logic              misaligned;
  logic              range_err;

  modport master (output req, sel, input ready, valid, out, misaligned, range_err);
  modport slave  (input req, sel, output ready, valid, out, misaligned, range_err);
endinterface

// File: rtl/imem_fetch_unit.sv
// Word-organised instruction memory with a req/valid fetch handshake, configurable wait
// states and a program-load port; bad byte addresses return zero with error flags.
module imem_fetch_unit #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32,
  localparam int AW         = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              reset,
  imem_fetch_if.slave      fetch,
  input logic              load_en,
  input logic [AW-1:0]     load_addr,
  input logic [DATA_W-1:0] load_data
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;
  logic [ADDR_W-1:0] addr_q, rd_addr, rd_word;
  logic [AW-1:0]     rd_idx;
  logic              rd_mis, rd_rng;
  logic              latch, capture;
  logic [DATA_W-1:0] out_q;
  logic              mis_q, rng_q;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Without wait states the result is registered on the accepting edge, before addr_q holds sel.
  assign rd_addr = (state == IDLE) ? fetch.sel : addr_q;
  assign rd_word = rd_addr >> OFS;
  assign rd_idx  = rd_word[AW-1:0];
  assign rd_mis  = (rd_addr & BYTE_MASK) != '0;
  assign rd_rng  = rd_word >= DEPTH_A;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch      = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch.req) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            capture    = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      out_q  <= '0;
      mis_q  <= 1'b0;
      rng_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (latch) addr_q <= fetch.sel;
      if (capture) begin
        mis_q <= rd_mis;
        rng_q <= rd_rng;
        out_q <= (rd_mis || rd_rng) ? '0 : mem[rd_idx];
      end
    end
  end

  assign fetch.ready      = (state == IDLE);
  assign fetch.valid      = (state == RESP);
  assign fetch.out        = out_q;
  assign fetch.misaligned = mis_q;
  assign fetch.range_err  = rng_q;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed literal cases, randomized traffic checked every cycle
// against an edge-counting reference model, and a zero-wait-state back-to-back instance.
module tb_imem_fetch_unit;
  localparam int WS  = 2;
  localparam int DEP = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, ld0_en;
  logic [3:0]  load_addr, ld0_addr;
  logic [31:0] load_data, ld0_data;
  int          checks = 0;
  int          fails  = 0;
  bit          checking = 1'b0;

  imem_fetch_if #(.ADDR_W(32), .DATA_W(32)) fif ();
  imem_fetch_if #(.ADDR_W(32), .DATA_W(32)) fif0 ();

  imem_fetch_unit #(.DATA_W(32), .DEPTH(DEP), .WAIT_STATES(WS), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .fetch(fif),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_fetch_unit #(.DATA_W(32), .DEPTH(DEP), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset), .fetch(fif0),
    .load_en(ld0_en), .load_addr(ld0_addr), .load_data(ld0_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a fetch resolves on the (WS+1)-th edge counted from acceptance, reading old memory.
  logic [31:0] mmem [DEP];
  bit          busy = 1'b0;
  int          k = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_out = '0;
  bit          m_mis = 1'b0;
  bit          m_rng = 1'b0;

  always @(posedge clk) if (load_en) mmem[load_addr] <= load_data;

  task automatic resolve(input logic [31:0] a);
    m_mis = (a % 4) != 0;
    m_rng = (a / 4) >= DEP;
    m_out = (!m_mis && !m_rng) ? mmem[a[5:2]] : 32'h0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy = 1'b0; k = 0; m_out = '0; m_mis = 1'b0; m_rng = 1'b0;
    end else if (busy) begin
      if (k == WS + 1) busy = 1'b0;
      else begin
        k++;
        if (k == WS + 1) resolve(m_addr);
      end
    end else if (fif.req) begin
      busy = 1'b1; k = 1; m_addr = fif.sel;
      if (k == WS + 1) resolve(m_addr);
    end
  end

  always @(negedge clk) begin
    if (checking && !reset) begin
      checkOutput("model_ready", 32'(fif.ready), 32'(!busy));
      checkOutput("model_valid", 32'(fif.valid), 32'(busy && k == WS + 1));
      checkOutput("model_out", fif.out, m_out);
      checkOutput("model_misaligned", 32'(fif.misaligned), 32'(m_mis));
      checkOutput("model_range_err", 32'(fif.range_err), 32'(m_rng));
    end
  end

  task automatic applyStimulus(input bit rq, input logic [31:0] s, input bit le,
                               input logic [3:0] la, input logic [31:0] ld);
    @(negedge clk);
    #1;
    fif.req = rq; fif.sel = s; load_en = le; load_addr = la; load_data = ld;
  endtask

  // Returns the result and the edge count from acceptance (inclusive) to the valid cycle.
  task automatic doFetch(input logic [31:0] a, input bit coll, input logic [31:0] cdata,
                         output logic [31:0] o, output bit mis, output bit rng, output int lat);
    bit got = 1'b0;
    lat = 0;
    @(negedge clk);
    for (int t = 0; t < 20 && !fif.ready; t++) @(negedge clk);
    if (!fif.ready) checkOutput("ready_wait", 32'(fif.ready), 32'd1);
    #1;
    fif.req = 1'b1; fif.sel = a;
    @(posedge clk);
    lat = 1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (fif.valid) begin got = 1'b1; break; end
      #1;
      fif.req = 1'b0;
      if (coll && lat + 1 == WS + 1) begin
        load_en = 1'b1; load_addr = a[5:2]; load_data = cdata;
      end
      @(posedge clk);
      lat++;
    end
    if (!got) checkOutput("valid_timeout", 32'(fif.valid), 32'd1);
    o = fif.out; mis = fif.misaligned; rng = fif.range_err;
    #1;
    fif.req = 1'b0; load_en = 1'b0;
  endtask

  initial begin
    logic [31:0] o, s;
    bit          mis, rng;
    int          lat, vcount, cat;

    reset = 1'b1;
    fif.req = 1'b0; fif.sel = '0; fif0.req = 1'b0; fif0.sel = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    ld0_en = 1'b0; ld0_addr = '0; ld0_data = '0;

    for (int i = 0; i < DEP; i++) begin
      @(negedge clk);
      #1;
      load_en = 1'b1; load_addr = 4'(i);
      load_data = (i == 3) ? 32'h20000003 : (i == 5) ? 32'hAAAA0000 : $urandom;
      ld0_en = (i < 2); ld0_addr = 4'(i);
      ld0_data = (i == 0) ? 32'h11110000 : 32'h22220001;
    end
    @(negedge clk);
    #1;
    load_en = 1'b0; ld0_en = 1'b0;

    @(negedge clk);
    checkOutput("reset_ready", 32'(fif.ready), 32'd1);
    checkOutput("reset_valid", 32'(fif.valid), 32'd0);
    checkOutput("reset_out", fif.out, 32'd0);
    checkOutput("reset_misaligned", 32'(fif.misaligned), 32'd0);
    checkOutput("reset_range_err", 32'(fif.range_err), 32'd0);
    checkOutput("reset_ready0", 32'(fif0.ready), 32'd1);
    #1;
    reset = 1'b0;
    checking = 1'b1;

    doFetch(32'd12, 1'b0, '0, o, mis, rng, lat);
    checkOutput("fetch12_latency", 32'(lat), 32'(WS + 1));
    checkOutput("fetch12_out", o, 32'h20000003);
    checkOutput("fetch12_flags", {30'd0, mis, rng}, 32'd0);
    @(negedge clk);
    checkOutput("fetch12_ready_after", 32'(fif.ready), 32'd1);

    doFetch(32'd13, 1'b0, '0, o, mis, rng, lat);
    checkOutput("mis13_out", o, 32'd0);
    checkOutput("mis13_flags", {30'd0, mis, rng}, 32'd2);
    doFetch(32'd12, 1'b0, '0, o, mis, rng, lat);
    checkOutput("refetch12_out", o, 32'h20000003);
    checkOutput("refetch12_flags", {30'd0, mis, rng}, 32'd0);

    doFetch(32'd64, 1'b0, '0, o, mis, rng, lat);
    checkOutput("range64_out", o, 32'd0);
    checkOutput("range64_flags", {30'd0, mis, rng}, 32'd1);
    doFetch(32'hFFFFFFFE, 1'b0, '0, o, mis, rng, lat);
    checkOutput("both_out", o, 32'd0);
    checkOutput("both_flags", {30'd0, mis, rng}, 32'd3);

    doFetch(32'd20, 1'b1, 32'h5555FFFF, o, mis, rng, lat);
    checkOutput("collision_old", o, 32'hAAAA0000);
    doFetch(32'd20, 1'b0, '0, o, mis, rng, lat);
    checkOutput("collision_new", o, 32'h5555FFFF);

    @(negedge clk);
    #1;
    fif.req = 1'b1; fif.sel = 32'd12;
    @(posedge clk);
    #1;
    fif.req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_ready", 32'(fif.ready), 32'd1);
    checkOutput("async_valid", 32'(fif.valid), 32'd0);
    checkOutput("async_out", fif.out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fif.valid) vcount++;
    end
    checkOutput("no_valid_after_reset", 32'(vcount), 32'd0);
    doFetch(32'd12, 1'b0, '0, o, mis, rng, lat);
    checkOutput("post_reset_out", o, 32'h20000003);

    for (int i = 0; i < 400; i++) begin
      cat = $urandom_range(0, 3);
      case (cat)
        0:       s = 32'($urandom_range(0, 15)) << 2;
        1:       s = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        2:       s = 32'($urandom_range(16, 1000)) << 2;
        default: s = $urandom;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), s, $urandom_range(0, 3) == 0,
                    4'($urandom_range(0, 15)), $urandom);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, '0);
    repeat (6) @(negedge clk);

    // Zero-wait-state instance: req held through RESP must not start a second fetch early.
    @(negedge clk);
    #1;
    fif0.req = 1'b1; fif0.sel = 32'd0;
    @(negedge clk);
    checkOutput("b2b_valid_first", 32'(fif0.valid), 32'd1);
    checkOutput("b2b_out_first", fif0.out, 32'h11110000);
    #1;
    fif0.sel = 32'd4;
    @(negedge clk);
    checkOutput("b2b_gap_valid", 32'(fif0.valid), 32'd0);
    checkOutput("b2b_gap_ready", 32'(fif0.ready), 32'd1);
    @(negedge clk);
    checkOutput("b2b_valid_second", 32'(fif0.valid), 32'd1);
    checkOutput("b2b_out_second", fif0.out, 32'h22220001);
    #1;
    fif0.req = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
